// File: rtl/karatsuba_operand_feeder.sv
// Operand front end for the folded Karatsuba multiplier: buffers X/Y pairs, issues limb pre-sums.
// Accept-to-issue latency 2 cycles; s_ready drops when the FIFO is full; issue stalls at MAX_OUTSTANDING.

module karatsuba_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_dat,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;

   // storage carries no reset; only the pointers and count define contents
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= wr_dat;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign rd_dat = mem[rd_ptr];
   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);
endmodule

module karatsuba_operand_feeder #(
   parameter int FIFO_DEPTH      = 2,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [127:0] s_x,
   input  logic [255:0] s_y,
   output logic         mul_in_valid,
   output logic [127:0] mul_x,
   output logic [127:0] mul_y,
   output logic [64:0]  mul_x1x0,
   output logic [64:0]  mul_y1y0,
   output logic [64:0]  mul_y2y0,
   output logic [64:0]  mul_y2y1,
   output logic [64:0]  mul_y3y0,
   output logic [64:0]  mul_y3y1,
   input  logic         credit_return,
   output logic [7:0]   outstanding,
   output logic         idle,
   output logic         credit_err
);
   localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

   logic         fifo_full;
   logic         fifo_empty;
   logic [383:0] head;
   logic [127:0] head_x;
   logic [255:0] head_y;
   logic         push;
   logic         issue;

   function automatic logic [64:0] presum(input logic [63:0] a, input logic [63:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   karatsuba_fifo #(
      .WIDTH(384),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clock  (clock),
      .reset  (reset),
      .push   (push),
      .wr_dat ({s_y, s_x}),
      .pop    (issue),
      .rd_dat (head),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign head_x  = head[127:0];
   assign head_y  = head[383:128];
   assign s_ready = !fifo_full;
   assign push    = s_valid && s_ready;
   assign issue   = !fifo_empty && (outstanding < MAX_OUT);
   assign idle    = fifo_empty && (outstanding == 8'd0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mul_in_valid <= 1'b0;
         mul_x        <= '0;
         mul_y        <= '0;
         mul_x1x0     <= '0;
         mul_y1y0     <= '0;
         mul_y2y0     <= '0;
         mul_y2y1     <= '0;
         mul_y3y0     <= '0;
         mul_y3y1     <= '0;
      end else begin
         mul_in_valid <= issue;
         if (issue) begin
            mul_x    <= head_x;
            mul_y    <= head_y[127:0];
            mul_x1x0 <= presum(head_x[127:64], head_x[63:0]);
            mul_y1y0 <= presum(head_y[127:64], head_y[63:0]);
            mul_y2y0 <= presum(head_y[191:128], head_y[63:0]);
            mul_y2y1 <= presum(head_y[191:128], head_y[127:64]);
            mul_y3y0 <= presum(head_y[255:192], head_y[63:0]);
            mul_y3y1 <= presum(head_y[255:192], head_y[127:64]);
         end
      end
   end

   // a credit landing on the same edge as an issue cancels it, even at zero
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         outstanding <= 8'd0;
         credit_err  <= 1'b0;
      end else if (issue && !credit_return) begin
         outstanding <= outstanding + 8'd1;
      end else if (!issue && credit_return) begin
         if (outstanding != 8'd0) outstanding <= outstanding - 8'd1;
         else                     credit_err  <= 1'b1;
      end
   end
endmodule

// File: tb/tb_karatsuba_operand_feeder.sv
// Randomized and directed checks of karatsuba_operand_feeder against a queue-based reference model.
module tb_karatsuba_operand_feeder;
   localparam int FIFO_DEPTH = 2;
   localparam int MAX_OUT    = 8;

   logic         clock = 1'b0;
   logic         reset;
   logic         s_valid;
   logic         s_ready;
   logic [127:0] s_x;
   logic [255:0] s_y;
   logic         mul_in_valid;
   logic [127:0] mul_x;
   logic [127:0] mul_y;
   logic [64:0]  mul_x1x0, mul_y1y0, mul_y2y0, mul_y2y1, mul_y3y0, mul_y3y1;
   logic         credit_return;
   logic [7:0]   outstanding;
   logic         idle;
   logic         credit_err;

   karatsuba_operand_feeder #(
      .FIFO_DEPTH(FIFO_DEPTH),
      .MAX_OUTSTANDING(MAX_OUT)
   ) dut (
      .clock(clock), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
      .s_x(s_x), .s_y(s_y), .mul_in_valid(mul_in_valid), .mul_x(mul_x), .mul_y(mul_y),
      .mul_x1x0(mul_x1x0), .mul_y1y0(mul_y1y0), .mul_y2y0(mul_y2y0), .mul_y2y1(mul_y2y1),
      .mul_y3y0(mul_y3y0), .mul_y3y1(mul_y3y1), .credit_return(credit_return),
      .outstanding(outstanding), .idle(idle), .credit_err(credit_err)
   );

   always #5 clock = ~clock;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model: pending pairs as {y, x}, counters as plain integers
   logic [383:0] q[$];
   logic [383:0] last;
   int           m_out;
   bit           m_err;
   bit           last_acc;
   bit           last_iss;
   int           iss_cnt;

   function automatic logic [64:0] ps(input logic [63:0] a, input logic [63:0] b);
      return 65'(a) + 65'(b);
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input bit exp_vld);
      logic [127:0] ex;
      logic [255:0] ey;
      ex = last[127:0];
      ey = last[383:128];
      chk("mul_in_valid", 384'(mul_in_valid), 384'(exp_vld));
      chk("s_ready", 384'(s_ready), 384'(q.size() < FIFO_DEPTH));
      chk("idle", 384'(idle), 384'(q.size() == 0 && m_out == 0));
      chk("outstanding", 384'(outstanding), 384'(m_out));
      chk("credit_err", 384'(credit_err), 384'(m_err));
      chk("mul_x", 384'(mul_x), 384'(ex));
      chk("mul_y", 384'(mul_y), 384'(ey[127:0]));
      chk("mul_x1x0", 384'(mul_x1x0), 384'(ps(ex[127:64], ex[63:0])));
      chk("mul_y1y0", 384'(mul_y1y0), 384'(ps(ey[127:64], ey[63:0])));
      chk("mul_y2y0", 384'(mul_y2y0), 384'(ps(ey[191:128], ey[63:0])));
      chk("mul_y2y1", 384'(mul_y2y1), 384'(ps(ey[191:128], ey[127:64])));
      chk("mul_y3y0", 384'(mul_y3y0), 384'(ps(ey[255:192], ey[63:0])));
      chk("mul_y3y1", 384'(mul_y3y1), 384'(ps(ey[255:192], ey[127:64])));
   endtask

   task automatic step(input logic v, input logic [127:0] x, input logic [255:0] y, input logic cr);
      bit acc, iss;
      s_valid = v; s_x = x; s_y = y; credit_return = cr;
      acc = v && (q.size() < FIFO_DEPTH);
      iss = (q.size() > 0) && (m_out < MAX_OUT);
      @(posedge clock); #1;
      if (iss) begin
         last = q.pop_front();
         iss_cnt++;
      end
      if (acc) q.push_back({y, x});
      if (iss && !cr) m_out++;
      else if (!iss && cr) begin
         if (m_out > 0) m_out--;
         else m_err = 1'b1;
      end
      last_acc = acc;
      last_iss = iss;
      s_valid = 1'b0; credit_return = 1'b0;
      check_outputs(iss);
   endtask

   task automatic push_until(input logic [127:0] x, input logic [255:0] y);
      bit done = 1'b0;
      for (int k = 0; k < 30 && !done; k++) begin
         step(1'b1, x, y, 1'b0);
         done = last_acc;
      end
      chk("push_bound", 384'(done), 384'(1));
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int k = 0; k < 60 && !ok; k++) begin
         if (q.size() == 0 && m_out == 0) ok = 1'b1;
         else step(1'b0, '0, '0, (m_out > 0) ? 1'b1 : 1'b0);
      end
      chk("drain_bound", 384'(ok), 384'(1));
   endtask

   task automatic model_reset();
      q.delete();
      last  = '0;
      m_out = 0;
      m_err = 1'b0;
   endtask

   initial begin
      logic [127:0] ones128;
      logic [255:0] ones256;
      logic [64:0]  big;
      ones128 = '1;
      ones256 = '1;
      big     = 65'h1_FFFF_FFFF_FFFF_FFFE;
      iss_cnt = 0;
      s_valid = 0; s_x = '0; s_y = '0; credit_return = 0;
      reset = 1'b0;
      model_reset();
      #12;
      check_outputs(1'b0);
      @(negedge clock) reset = 1'b1;

      // single all-ones operation
      step(1'b1, ones128, ones256, 1'b0);
      step(1'b0, '0, '0, 1'b0);
      chk("single_vld", 384'(mul_in_valid), 384'(1));
      chk("single_x1x0", 384'(mul_x1x0), 384'(big));
      chk("single_y3y1", 384'(mul_y3y1), 384'(big));
      chk("single_out", 384'(outstanding), 384'(1));
      step(1'b0, '0, '0, 1'b0);
      chk("single_once", 384'(mul_in_valid), 384'(0));
      drain();

      // throttle and full-FIFO backpressure, X0 = 1..10
      iss_cnt = 0;
      for (int i = 1; i <= 10; i++) push_until({rnd128()} & {64'hFFFF_FFFF_FFFF_FFFF, 64'h0} | 128'(i), {rnd128(), rnd128()});
      for (int k = 0; k < 3; k++) step(1'b1, rnd128(), {rnd128(), rnd128()}, 1'b0);
      chk("throttle_issues", 384'(iss_cnt), 384'(8));
      chk("throttle_out", 384'(outstanding), 384'(8));
      chk("throttle_ready", 384'(s_ready), 384'(0));
      chk("throttle_noacc", 384'(last_acc), 384'(0));
      step(1'b0, '0, '0, 1'b1);
      step(1'b0, '0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b0);
      chk("credit_one_issue", 384'(iss_cnt), 384'(9));
      chk("credit_out", 384'(outstanding), 384'(8));
      drain();

      // issue and credit together at outstanding 3
      for (int i = 0; i < 3; i++) push_until(rnd128(), {rnd128(), rnd128()});
      step(1'b0, '0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b0);
      step(1'b1, rnd128(), {rnd128(), rnd128()}, 1'b0);
      step(1'b0, '0, '0, 1'b1);
      chk("simul_iss", 384'(last_iss), 384'(1));
      chk("simul_out3", 384'(outstanding), 384'(3));
      drain();

      // credit offsetting an issue at zero is legal
      step(1'b1, rnd128(), {rnd128(), rnd128()}, 1'b0);
      step(1'b0, '0, '0, 1'b1);
      chk("zero_offset_out", 384'(outstanding), 384'(0));
      chk("zero_offset_err", 384'(credit_err), 384'(0));

      // back-to-back issue
      for (int k = 0; k < 6; k++) begin
         if (k < 4) step(1'b1, rnd128(), {rnd128(), rnd128()}, 1'b0);
         else       step(1'b0, '0, '0, 1'b0);
         chk("b2b_vld", 384'(mul_in_valid), 384'(k >= 1 && k <= 4));
      end
      drain();

      // randomized traffic
      for (int k = 0; k < 400; k++)
         step(1'($urandom_range(0, 1)), rnd128(), {rnd128(), rnd128()},
              ($urandom_range(0, 2) == 0 && m_out > 0) ? 1'b1 : 1'b0);
      drain();

      // stray credit
      step(1'b0, '0, '0, 1'b1);
      chk("stray_err", 384'(credit_err), 384'(1));
      chk("stray_out", 384'(outstanding), 384'(0));
      step(1'b0, '0, '0, 1'b0);
      chk("err_sticky", 384'(credit_err), 384'(1));

      // asynchronous reset mid-stream with work queued and outstanding
      for (int i = 0; i < 10; i++) push_until(rnd128(), {rnd128(), rnd128()});
      step(1'b0, '0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b0);
      chk("pre_reset_queued", 384'(q.size()), 384'(2));
      #2 reset = 1'b0;
      model_reset();
      #1;
      chk("arst_vld", 384'(mul_in_valid), 384'(0));
      chk("arst_idle", 384'(idle), 384'(1));
      check_outputs(1'b0);
      @(negedge clock);
      @(negedge clock) reset = 1'b1;
      iss_cnt = 0;
      for (int k = 0; k < 5; k++) step(1'b0, '0, '0, 1'b0);
      chk("post_reset_noissue", 384'(iss_cnt), 384'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
